// File: rtl/f_sub_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : f_sub_seq_if
// Description : Start/busy/done handshake and 64-bit FP register bus for the
//               multicycle single-precision subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface f_sub_seq_if;
  logic        start;
  logic [63:0] read_f_data1;
  logic [63:0] read_f_data2;
  logic        busy;
  logic        done;
  logic [63:0] alu_float_result;

  // Requester side: issues operands and start, observes status and result
  modport master (
    output start, read_f_data1, read_f_data2,
    input  busy, done, alu_float_result
  );

  // Subtractor side
  modport slave (
    input  start, read_f_data1, read_f_data2,
    output busy, done, alu_float_result
  );
endinterface
`default_nettype wire

// File: rtl/f_sub_seq.sv
`default_nettype none
// ============================================================================
// Module      : f_sub_seq
// Description : Multicycle IEEE-754 single-precision subtractor (a - b).
//               Aligns, adds/subtracts, then left-normalizes one bit per
//               cycle. Truncates (no rounding), flushes denormals to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module f_sub_seq (
  input  wire logic  clk,
  input  wire logic  rst_n,
  f_sub_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_SUB   = 3'd2,
    ST_NORM  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;           // minuend as latched
  logic [31:0] b_q, b_d;           // subtrahend with sign already inverted
  logic        nan_q, nan_d;       // an operand had exponent 255
  logic        sign_q, sign_d;     // sign of the big operand / result
  logic        sign_s_q, sign_s_d; // sign of the small operand
  logic [8:0]  exp_q, exp_d;       // working exponent
  logic [24:0] mant_q, mant_d;     // big mantissa, then working mantissa
  logic [24:0] mant_s_q, mant_s_d; // aligned small mantissa
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Low halves of the operand registers carry no information
  logic unused_low;
  assign unused_low = ^{bus.read_f_data1[31:0], bus.read_f_data2[31:0]};

  // Operand ordering and alignment, evaluated from the latched operands
  logic        w_a_big;
  logic [31:0] w_big, w_small;
  logic [24:0] w_m_big, w_m_small, w_m_small_sh;
  logic [7:0]  w_ediff;
  logic [25:0] w_sum;
  logic [8:0]  w_exp_inc;

  // Datapath helpers shared by ALIGN and SUB
  always_comb begin
    w_a_big      = (a_q[30:0] >= b_q[30:0]);
    w_big        = w_a_big ? a_q : b_q;
    w_small      = w_a_big ? b_q : a_q;
    // Exponent 0 is flushed to zero: no hidden bit, fraction discarded
    w_m_big      = (w_big[30:23] == 8'd0)   ? 25'd0 : {1'b1, w_big[22:0], 1'b0};
    w_m_small    = (w_small[30:23] == 8'd0) ? 25'd0 : {1'b1, w_small[22:0], 1'b0};
    w_ediff      = w_big[30:23] - w_small[30:23];
    w_m_small_sh = (w_ediff >= 8'd25) ? 25'd0 : (w_m_small >> w_ediff);
    w_sum        = (sign_q == sign_s_q) ? ({1'b0, mant_q} + {1'b0, mant_s_q})
                                        : ({1'b0, mant_q} - {1'b0, mant_s_q});
    w_exp_inc    = exp_q + 9'd1;
  end

  // Next-state and next-register computation for the sequencer
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    nan_d    = nan_q;
    sign_d   = sign_q;
    sign_s_d = sign_s_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    mant_s_d = mant_s_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.read_f_data1[63:32];
          b_d     = {~bus.read_f_data2[63], bus.read_f_data2[62:32]};
          state_d = ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        // NaN/Inf is only flagged here so every special case exits from SUB
        nan_d    = (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
        sign_d   = w_big[31];
        sign_s_d = w_small[31];
        exp_d    = {1'b0, w_big[30:23]};
        mant_d   = w_m_big;
        mant_s_d = w_m_small_sh;
        state_d  = ST_SUB;
      end

      ST_SUB: begin
        if (nan_q) begin
          result_d = C_QNAN;
          state_d  = ST_DONE;
        end else if (w_sum == 26'd0) begin
          result_d = 32'd0;
          state_d  = ST_DONE;
        end else if (w_sum[25]) begin
          if (w_exp_inc == 9'd255) begin
            result_d = {sign_q, 8'hFF, 23'd0};
            state_d  = ST_DONE;
          end else begin
            mant_d  = w_sum[25:1];
            exp_d   = w_exp_inc;
            state_d = ST_NORM;
          end
        end else begin
          mant_d  = w_sum[24:0];
          state_d = ST_NORM;
        end
      end

      ST_NORM: begin
        if (mant_q[24]) begin
          result_d = {sign_q, exp_q[7:0], mant_q[23:1]};
          state_d  = ST_DONE;
        end else if (exp_q == 9'd1) begin
          result_d = 32'd0;
          state_d  = ST_DONE;
        end else begin
          mant_d = {mant_q[23:0], 1'b0};
          exp_d  = exp_q - 9'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered off the next state so they line up with it
    busy_d = (state_d == ST_ALIGN) || (state_d == ST_SUB) || (state_d == ST_NORM);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      nan_q    <= 1'b0;
      sign_q   <= 1'b0;
      sign_s_q <= 1'b0;
      exp_q    <= 9'd0;
      mant_q   <= 25'd0;
      mant_s_q <= 25'd0;
      result_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      nan_q    <= nan_d;
      sign_q   <= sign_d;
      sign_s_q <= sign_s_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      mant_s_q <= mant_s_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.alu_float_result = {result_q, 32'd0};

endmodule
`default_nettype wire
